// File: rtl/meas_sig_gen.sv
`default_nettype none
// ============================================================================
//  Module      : meas_sig_gen
//  Description : Programmable square-wave burst generator. Emits a pulse
//                train of exactly known high/low phase lengths and pulse
//                count, and reports how many full pulses were emitted.
//                Optional feature macro: MEAS_GEN_DUTY_EN (adds low_period
//                input for a programmable duty cycle; otherwise 50 % duty).
//  Revision    : 1.0 - initial release
// ============================================================================
module meas_sig_gen #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] half_period,
`ifdef MEAS_GEN_DUTY_EN
    input  logic [DIV_W-1:0] low_period,
`endif
    input  logic [CNT_W-1:0] pulse_count,
    input  logic             start,
    input  logic             stop,
    output logic             MeasuredSignal,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] C_DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t             state_q,  state_d;
    logic [DIV_W-1:0]   phase_q,  phase_d;
    logic [DIV_W-1:0]   hi_len_q, hi_len_d;
    logic [DIV_W-1:0]   lo_len_q, lo_len_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   pulses_q, pulses_d;
    logic               done_evt_q, done_evt_d;

    logic               sig_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   pulses_out_q;

    logic [DIV_W-1:0]   hi_in;
    logic [DIV_W-1:0]   lo_in;
    logic [CNT_W-1:0]   pulses_inc;

    // Zero phase lengths are promoted to one cycle so a phase never stalls.
    assign hi_in = (half_period == '0) ? C_DIV_ONE : half_period;
`ifdef MEAS_GEN_DUTY_EN
    assign lo_in = (low_period == '0) ? C_DIV_ONE : low_period;
`else
    assign lo_in = hi_in;
`endif

    assign pulses_inc = pulses_q + C_CNT_ONE;

    // Next-state logic: phase counting, pulse accounting and abort handling.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        hi_len_d   = hi_len_q;
        lo_len_d   = lo_len_q;
        target_d   = target_q;
        pulses_d   = pulses_q;
        done_evt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // start outranks stop while idle; stop alone does nothing here.
                if (start) begin
                    hi_len_d = hi_in;
                    lo_len_d = lo_in;
                    target_d = pulse_count;
                    pulses_d = '0;
                    phase_d  = hi_in;
                    state_d  = S_HIGH;
                end
            end
            S_HIGH: begin
                if (stop) begin
                    done_evt_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (phase_q <= C_DIV_ONE) begin
                    phase_d = lo_len_q;
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q - C_DIV_ONE;
                end
            end
            S_LOW: begin
                // An aborted low phase is a partial pulse and is not counted.
                if (stop) begin
                    done_evt_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (phase_q <= C_DIV_ONE) begin
                    pulses_d = pulses_inc;
                    if ((target_q != '0) && (pulses_inc == target_q)) begin
                        done_evt_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        phase_d = hi_len_q;
                        state_d = S_HIGH;
                    end
                end else begin
                    phase_d = phase_q - C_DIV_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Core state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            hi_len_q   <= '0;
            lo_len_q   <= '0;
            target_q   <= '0;
            pulses_q   <= '0;
            done_evt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            hi_len_q   <= hi_len_d;
            lo_len_q   <= lo_len_d;
            target_q   <= target_d;
            pulses_q   <= pulses_d;
            done_evt_q <= done_evt_d;
        end
    end

    // Output register stage: every output is a flop fed only from core state,
    // so all outputs move together one edge after the core decision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sig_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pulses_out_q <= '0;
        end else begin
            sig_q        <= (state_q == S_HIGH);
            busy_q       <= (state_q != S_IDLE);
            done_q       <= done_evt_q;
            pulses_out_q <= pulses_q;
        end
    end

    assign MeasuredSignal = sig_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pulses_sent    = pulses_out_q;

endmodule
`default_nettype wire

// File: tb/tb_meas_sig_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_meas_sig_gen
//  Description : Directed self-checking bench for meas_sig_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_meas_sig_gen;

    logic        clk;
    logic        reset;
    logic [15:0] half_period;
`ifdef MEAS_GEN_DUTY_EN
    logic [15:0] low_period;
`endif
    logic [7:0]  pulse_count;
    logic        start;
    logic        stop;
    logic        MeasuredSignal;
    logic        busy;
    logic        done;
    logic [7:0]  pulses_sent;

    int n_chk = 0;
    int n_bad = 0;

    logic       sig_r  [0:699];
    logic       done_r [0:699];
    logic       busy_r [0:699];
    logic [7:0] pul_r  [0:699];

    meas_sig_gen #(.DIV_W(16), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .half_period    (half_period),
`ifdef MEAS_GEN_DUTY_EN
        .low_period     (low_period),
`endif
        .pulse_count    (pulse_count),
        .start          (start),
        .stop           (stop),
        .MeasuredSignal (MeasuredSignal),
        .busy           (busy),
        .done           (done),
        .pulses_sent    (pulses_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pulse start for one edge with the given config; stop is released too.
    task automatic go(input logic [15:0] hp, input logic [7:0] cnt);
        @(negedge clk);
        half_period = hp;
        pulse_count = cnt;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Record outputs at n falling edges; optionally inject a start or a stop.
    task automatic rec(input int n, input int inj, input int stp);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sig_r[k]  = MeasuredSignal;
            done_r[k] = done;
            busy_r[k] = busy;
            pul_r[k]  = pulses_sent;
            if (k == inj) begin
                start       = 1'b1;
                half_period = 16'd9;
            end else if (k == inj + 1) begin
                start = 1'b0;
            end
            if (k == stp) stop = 1'b1;
            else if (k == stp + 1) stop = 1'b0;
        end
    endtask

    initial begin
        int errs;
        reset       = 1'b0;
        start       = 1'b1;
        stop        = 1'b0;
        half_period = 16'd4;
        pulse_count = 8'd3;
`ifdef MEAS_GEN_DUTY_EN
        low_period  = 16'd0;
`endif
        // Reset held with start asserted: nothing may move.
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (MeasuredSignal !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pulses_sent !== 8'd0)
                errs++;
        end
        check("reset_outputs", errs, 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Finite burst 4/4 x3, with an ignored start (half=9) mid-burst.
        go(16'd4, 8'd3);
        rec(30, 10, -5);
        errs = 0;
        for (int k = 0; k < 30; k++)
            if (sig_r[k] !== ((k >= 1 && k <= 24 && ((k - 1) % 8) < 4) ? 1'b1 : 1'b0)) errs++;
        check("burst_wave", errs, 0);
        check("burst_busy_first", busy_r[1], 1);
        check("burst_pul_first", pul_r[9], 1);
        check("burst_done_early", done_r[24], 0);
        check("burst_busy_last", busy_r[24], 1);
        check("burst_done", done_r[25], 1);
        check("burst_pulses", pul_r[25], 3);
        check("burst_busy_end", busy_r[25], 0);
        check("burst_done_once", done_r[26], 0);

        // Zero phase length behaves as one cycle.
        go(16'd0, 8'd2);
        rec(8, -5, -5);
        errs = 0;
        for (int k = 0; k < 8; k++)
            if (sig_r[k] !== ((k >= 1 && k <= 4 && (k % 2) == 1) ? 1'b1 : 1'b0)) errs++;
        check("zero_wave", errs, 0);
        check("zero_done", done_r[5], 1);
        check("zero_pulses", pul_r[5], 2);

        // Continuous mode, abort during a high output cycle.
        go(16'd1, 8'd0);
        rec(606, -5, 601);
        errs = 0;
        for (int k = 1; k <= 601; k++)
            if (sig_r[k] !== ((k % 2) == 1 ? 1'b1 : 1'b0)) errs++;
        check("cont_wave", errs, 0);
        check("cont_pulses", pul_r[601], 44);
        check("cont_no_done", done_r[602], 0);
        check("cont_stop_sig", sig_r[603], 0);
        check("cont_stop_done", done_r[603], 1);
        check("cont_stop_pulses", pul_r[603], 44);
        check("cont_stop_busy", busy_r[603], 0);
        check("cont_done_once", done_r[604], 0);

        // Stop while idle has no effect.
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || pulses_sent !== 8'd44) errs++;
        end
        check("idle_stop", errs, 0);

        // Start together with stop in idle: start wins.
        stop = 1'b1;
        go(16'd2, 8'd1);
        rec(8, -5, -5);
        check("startstop_busy", busy_r[1], 1);
        check("startstop_sig", sig_r[2], 1);
        check("startstop_low", sig_r[3], 0);
        check("startstop_done", done_r[5], 1);
        check("startstop_pulses", pul_r[5], 1);

`ifdef MEAS_GEN_DUTY_EN
        // Programmable duty: 2 high / 6 low, two pulses.
        low_period = 16'd6;
        go(16'd2, 8'd2);
        rec(20, -5, -5);
        errs = 0;
        for (int k = 0; k < 20; k++)
            if (sig_r[k] !== ((k >= 1 && k <= 16 && ((k - 1) % 8) < 2) ? 1'b1 : 1'b0)) errs++;
        check("duty_wave", errs, 0);
        check("duty_done_early", done_r[16], 0);
        check("duty_done", done_r[17], 1);
        check("duty_pulses", pul_r[17], 2);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/meas_sig_gen.md
# meas_sig_gen

Programmable square-wave burst generator driving the `MeasuredSignal` input of the aging-sensor edge counter, so the counter and display path can be calibrated against a pulse train of exactly known period and pulse count. The generator sits beside the counter in the display-controller test build, shares its clock, and reports how many full pulses it has emitted. Firmware or the test sequencer loads a period and a pulse count, pulses `start`, then compares `pulses_sent` with the counter's `count`.

## Interface
- `DIV_W`, 16, width of the phase-length registers
- `CNT_W`, 8, width of the pulse-count fields (matches counter `count` width)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `half_period`  in  DIV_W  high-phase length in clk cycles; also the low-phase length when the macro is off; 0 treated as 1
- `low_period`  in  DIV_W  low-phase length in clk cycles; 0 treated as 1; present only with `MEAS_GEN_DUTY_EN`
- `pulse_count`  in  CNT_W  pulses per burst; 0 = continuous until `stop`
- `start`  in  1  one-cycle request; latches the config inputs
- `stop`  in  1  abort request
- `MeasuredSignal`  out  1  generated waveform
- `busy`  out  1  high from the cycle after an accepted `start` until return to IDLE
- `done`  out  1  one-cycle pulse at burst end or abort
- `pulses_sent`  out  CNT_W  completed pulses in the current or last burst

## Operation
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - `MeasuredSignal` = 0, `busy` = 0.
  - On `start` = 1: latch `half_period`, `low_period` (or `half_period`) and `pulse_count` into shadow registers, clear `pulses_sent`, load the phase counter with the high length, go to HIGH.
- HIGH:
  - `MeasuredSignal` = 1; the phase counter decrements each cycle.
  - When the counter reaches 1: load the low length, go to LOW.
- LOW:
  - `MeasuredSignal` = 0.
  - When the counter reaches 1: increment `pulses_sent`.
  - If latched `pulse_count` ≠ 0 and the incremented value equals it: assert `done`, go to IDLE. Otherwise reload the high length and go to HIGH.
- Continuous mode (`pulse_count` = 0): `pulses_sent` wraps modulo 2^CNT_W and the burst never self-terminates.
- `stop` in HIGH or LOW: next cycle IDLE, `MeasuredSignal` = 0, `done` = 1, `pulses_sent` holds (the partial pulse is not counted).
- `stop` in IDLE: no effect.
- `start` while busy: ignored. Config inputs are sampled only on an accepted `start`, so changing them mid-burst has no effect.
- `start` and `stop` asserted together in IDLE: `start` wins. In HIGH/LOW: `stop` wins.
- `start` in the same cycle that `done` is asserted: accepted, with a new burst and no IDLE gap beyond that cycle.

## Timing
- Reset (`reset` = 0 at a clk edge): IDLE, `MeasuredSignal` = 0, `busy` = 0, `done` = 0, `pulses_sent` = 0, shadow registers = 0. Reset mid-burst aborts with no `done`.
- `start` sampled at edge N: `MeasuredSignal` and `busy` are 1 after edge N+1.
- High phase lasts exactly H cycles, low phase exactly L cycles; pulse period = H+L cycles.
- `pulses_sent` increments and `done` asserts on the same edge that ends the final low phase. `busy` drops on that edge.
- `stop` sampled at edge N: outputs are idle after edge N+1.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `MEAS_GEN_DUTY_EN` defined: the `low_period` port exists and the low phase uses the latched `low_period`, giving a programmable duty cycle.
- `MEAS_GEN_DUTY_EN` undefined: there is no `low_period` port and the low phase equals the latched `half_period`, giving a 50 % duty cycle.

## Test plan
- Reset check: hold `reset` = 0 for 3 cycles while driving `start` = 1 -> all outputs 0, no pulses.
- Finite burst: `half_period` = 4, `pulse_count` = 3, `start` -> 3 periods of 8 cycles (4 high / 4 low), `done` exactly 24 cycles after the first high cycle, `pulses_sent` = 3, `busy` low.
- Zero-length phase: `half_period` = 0, `pulse_count` = 2 -> 1 high / 1 low cycle per pulse, `done` after 4 cycles.
- Continuous mode with abort: `half_period` = 1, `pulse_count` = 0, run 600 cycles, then `stop` during a high phase -> `pulses_sent` = 300 mod 256 = 44, `MeasuredSignal` = 0 and `done` = 1 on the next cycle.
- Ignored inputs: while busy, pulse `start` with `half_period` = 9 -> no change to period or `pulses_sent`.
- Duty cycle (macro on): `half_period` = 2, `low_period` = 6, `pulse_count` = 2 -> 2 high / 6 low per pulse, `done` after 16 cycles. Feed into the edge counter and confirm `count` = 2.
